life_data_high: RTL and testbench
=================================

LIFE_DATA_HIGH -- requirements
Module: life_data_high

Interface
REQ-001 SHALL have parameter X, default 8: board width, in cells.
REQ-002 SHALL have parameter Y, default 8: board height, in cells.
REQ-003 SHALL have parameter HIGH_BITS, default 2*X+3: window length, in bits.
REQ-004 SHALL have parameter LOG2X, default 3: width of the column counter.
REQ-005 SHALL have parameter LOG2Y, default 3: width of the row counter.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port data_low_lsb, input, 1 bit: ring bit leaving the low segment, entering this block's MSB.
REQ-009 SHALL have port step, input, 1 bit: one-cycle request for one generation.
REQ-010 SHALL have port run, input, 1 bit: level request for continuous generations.
REQ-011 SHALL have port data_high_lsb, output, 1 bit: ring bit leaving this block toward the low segment's MSB.
REQ-012 SHALL have port busy, output, 1 bit: generation armed, computing or flushing.
REQ-013 SHALL have port gen_done, output, 1 bit: one-cycle pulse after the final writeback of a generation.
REQ-014 SHALL have port gen_count, output, 16 bits: count of completed generations.
REQ-015 SHALL have ports center_x and center_y, outputs, LOG2X and LOG2Y bits: coordinates of the cell at window[X+1].

Function
REQ-016 SHALL rotate the window every clk, unconditionally: window_next = {data_low_lsb, window[HIGH_BITS-1:1]}.
REQ-017 SHALL increment center_x every clk, wrapping at X-1; on wrap SHALL increment center_y, wrapping at Y-1; center index = center_y*X+center_x.
REQ-018 SHALL take neighbours of window[X+1] from window[0,1,2] (up), window[X] and window[X+2] (left, right), and window[2X,2X+1,2X+2] (down).
REQ-019 SHALL treat board edges as dead: center_x==0 masks 0,X,2X; center_x==X-1 masks 2,X+2,2X+2; center_y==0 masks 0,1,2; center_y==Y-1 masks 2X,2X+1,2X+2.
REQ-020 SHALL compute next = (count==3) | (window[X+1] & count==2), where count is a 4-bit sum of the unmasked neighbours.
REQ-021 SHALL push {valid, last, next} into a delay line of X+1 stages every clk; valid=1 only in COMPUTE; last=1 only at center index N-1 (N=X*Y).
REQ-022 SHALL drive data_high_lsb = delay[X].next when delay[X].valid, else window[0].
REQ-023 SHALL implement the FSM states IDLE, ARMED and COMPUTE.
REQ-024 SHALL move IDLE->ARMED on step or run; step SHALL be ignored outside IDLE.
REQ-025 SHALL move ARMED->COMPUTE on the edge where the center index goes N-1 -> 0.
REQ-026 SHALL hold COMPUTE for N cycles, covering center indices 0..N-1.
REQ-027 SHALL, at the end of COMPUTE, stay in COMPUTE when run=1, giving back-to-back generations with period N; otherwise it SHALL go to IDLE.
REQ-028 SHALL let the flush of generation g overlap the compute of generation g+1; masking guarantees stale cells are never consumed.
REQ-029 SHALL assert gen_done for exactly one cycle, on the cycle after delay[X].last&valid is output, and increment gen_count on the same edge (16-bit, wrapping).
REQ-030 SHALL drive busy = (state!=IDLE) | any delay.valid.
REQ-031 SHALL, when run drops mid-generation, finish the current generation and then go to IDLE.

Reset
REQ-032 SHALL, while reset=0, clear window, the delay line (valid/last/next), center_x, center_y, gen_count, gen_done and busy to 0, and set state=IDLE.
REQ-033 SHALL, on reset mid-generation, discard all pending writebacks; the ring passes through unchanged after release.

Structure
REQ-034 SHALL place N, the neighbour index constants, the edge-mask constants and the birth/survive constants (3, 2/3) in shared package life_pkg.
REQ-035 SHALL have one combinational sub-module, life_cell_rule: inputs 8 masked neighbours and center; output next.

Verification
All scenarios use X=Y=8, N=64, HIGH_BITS=19, with the board preloaded through the ring and the life_data_low counterpart.
REQ-036 SHALL check timing: step at any idx, COMPUTE starting at cycle T0 (idx 0) -> gen_done high exactly at T0+73; gen_count 0->1.
REQ-037 SHALL check a blinker: cells (3,2),(3,3),(3,4) -> after one step, (2,3),(3,3),(4,3) alive and all other cells dead.
REQ-038 SHALL check a still life: a 2x2 block at (0,0) -> unchanged after 3 steps; a lone cell at (5,5) -> dead after 1 step.
REQ-039 SHALL check edge masking: cells (7,1),(7,2),(0,2) -> no birth at (0,1) or (7,3); (7,1) and (0,2) die.
REQ-040 SHALL check run mode: run=1 for 4 generations -> gen_done pulses spaced exactly 64 cycles; blinker phase alternates correctly.
REQ-041 SHALL check reset mid-COMPUTE: reset low at idx 30 -> busy=0, gen_count=0, no gen_done pulse.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants for the Game of Life ring engine: FSM states, neighbour
// slot layout inside the sliding window, edge masks and the cell rule.
package life_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, COMPUTE} lifeState_e;

  localparam int BOARD_X = 8;
  localparam int BOARD_Y = 8;
  localparam int N       = BOARD_X * BOARD_Y;

  // Neighbour slots, row-major from up-left to down-right.
  localparam int NB_UL = 0;
  localparam int NB_U  = 1;
  localparam int NB_UR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_DL = 5;
  localparam int NB_D  = 6;
  localparam int NB_DR = 7;

  localparam logic [7:0] MASK_LEFT   = 8'b0010_1001;
  localparam logic [7:0] MASK_RIGHT  = 8'b1001_0100;
  localparam logic [7:0] MASK_TOP    = 8'b0000_0111;
  localparam logic [7:0] MASK_BOTTOM = 8'b1110_0000;

  localparam logic [3:0] BIRTH_COUNT = 4'd3;
  localparam logic [3:0] SURVIVE_MIN = 4'd2;
  localparam logic [3:0] SURVIVE_MAX = 4'd3;

  typedef struct packed {
    logic valid;
    logic last;
    logic next;
  } delayEntry_t;

  // Window bit holding a given neighbour slot when the centre sits at x+1.
  function automatic int nbIndex(input int slot, input int x);
    case (slot)
      NB_UL:   return 0;
      NB_U:    return 1;
      NB_UR:   return 2;
      NB_L:    return x;
      NB_R:    return x + 2;
      NB_DL:   return 2 * x;
      NB_D:    return 2 * x + 1;
      NB_DR:   return 2 * x + 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: births on exactly three live neighbours,
// survival on two or three.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [7:0] neighbours_i,
  input  logic       center_i,
  output logic       next_o
);

  logic [3:0] count;

  // Population count of the already-masked neighbours.
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(neighbours_i[i]);
    end
  end

  assign next_o = (count == BIRTH_COUNT) |
                  (center_i & (count >= SURVIVE_MIN) & (count <= SURVIVE_MAX));

endmodule

// File: rtl/life_data_high.sv
// High segment of the Life board ring: a sliding window that evaluates one
// cell per clock and writes results back as each cell leaves the window.
module life_data_high
  import life_pkg::*;
#(
  parameter int X         = BOARD_X,
  parameter int Y         = BOARD_Y,
  parameter int HIGH_BITS = 2 * X + 3,
  parameter int LOG2X     = 3,
  parameter int LOG2Y     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_low_lsb,
  input  logic             step,
  input  logic             run,
  output logic             data_high_lsb,
  output logic             busy,
  output logic             gen_done,
  output logic [15:0]      gen_count,
  output logic [LOG2X-1:0] center_x,
  output logic [LOG2Y-1:0] center_y
);

  localparam logic [LOG2X-1:0] X_LAST = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_LAST = LOG2Y'(Y - 1);

  lifeState_e              state_q;
  logic [HIGH_BITS-1:0]    window_q, window_d;
  logic [LOG2X-1:0]        centerX_q, centerX_d;
  logic [LOG2Y-1:0]        centerY_q, centerY_d;
  delayEntry_t             delay_q [X+1];
  logic                    genDone_q;
  logic [15:0]             genCount_q;

  logic                    lastX, lastY, lastCell;
  logic [7:0]              nbRaw, nbMask;
  logic                    cellNext;
  logic                    anyValid;
  delayEntry_t             pushEntry;

  assign lastX    = (centerX_q == X_LAST);
  assign lastY    = (centerY_q == Y_LAST);
  assign lastCell = lastX & lastY;

  // The window rotates and the centre walks the board every clock, busy or not.
  always_comb begin
    window_d  = {data_low_lsb, window_q[HIGH_BITS-1:1]};
    centerX_d = lastX ? '0 : centerX_q + 1'b1;
    centerY_d = centerY_q;
    if (lastX) begin
      centerY_d = lastY ? '0 : centerY_q + 1'b1;
    end
  end

  for (genvar s = 0; s < 8; s++) begin : g_nb
    assign nbRaw[s] = window_q[nbIndex(s, X)];
  end

  // Off-board neighbours hold wrapped or stale ring bits and must read as dead.
  always_comb begin
    nbMask = 8'hFF;
    if (centerX_q == '0) nbMask = nbMask & ~MASK_LEFT;
    if (lastX)           nbMask = nbMask & ~MASK_RIGHT;
    if (centerY_q == '0) nbMask = nbMask & ~MASK_TOP;
    if (lastY)           nbMask = nbMask & ~MASK_BOTTOM;
  end

  life_cell_rule u_rule (
    .neighbours_i (nbRaw & nbMask),
    .center_i     (window_q[X+1]),
    .next_o       (cellNext)
  );

  always_comb begin
    pushEntry.valid = (state_q == COMPUTE);
    pushEntry.last  = lastCell;
    pushEntry.next  = cellNext;
    anyValid        = 1'b0;
    for (int k = 0; k <= X; k++) begin
      anyValid = anyValid | delay_q[k].valid;
    end
  end

  // A result emerges from the delay line exactly when its cell reaches window[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      window_q   <= '0;
      centerX_q  <= '0;
      centerY_q  <= '0;
      genDone_q  <= 1'b0;
      genCount_q <= 16'd0;
      for (int k = 0; k <= X; k++) begin
        delay_q[k] <= '0;
      end
    end else begin
      window_q   <= window_d;
      centerX_q  <= centerX_d;
      centerY_q  <= centerY_d;
      delay_q[0] <= pushEntry;
      for (int k = 1; k <= X; k++) begin
        delay_q[k] <= delay_q[k-1];
      end
      genDone_q <= delay_q[X].valid & delay_q[X].last;
      if (delay_q[X].valid & delay_q[X].last) begin
        genCount_q <= genCount_q + 16'd1;
      end
      case (state_q)
        IDLE:    if (step | run) state_q <= ARMED;
        ARMED:   if (lastCell) state_q <= COMPUTE;
        COMPUTE: if (lastCell && !run) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_high_lsb = delay_q[X].valid ? delay_q[X].next : window_q[0];
  assign busy          = (state_q != IDLE) | anyValid;
  assign gen_done      = genDone_q;
  assign gen_count     = genCount_q;
  assign center_x      = centerX_q;
  assign center_y      = centerY_q;

endmodule

// File: tb/tb_life_data_high.sv
// Bench for life_data_high: models the low ring segment, loads boards through
// the ring and scores each generation against a plain 2-D Life model.
module tb_life_data_high;
  import life_pkg::*;

  localparam int X   = 8;
  localparam int Y   = 8;
  localparam int NC  = X * Y;
  localparam int HB  = 2 * X + 3;
  localparam int LOW = NC - HB;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        stepReq = 1'b0;
  logic        runReq = 1'b0;
  logic        loading = 1'b0;
  logic [63:0] loadImage = '0;
  logic        dataLowLsb;
  logic        dataHighLsb, busy, genDone;
  logic [15:0] genCount;
  logic [2:0]  centerX, centerY;

  logic [LOW-1:0] lowSeg = '0;
  logic [63:0]    ringView = '0;
  logic [63:0]    curBoard = '0;
  logic [15:0]    expCount = '0;
  int benchIdx = 0;
  int cycleCount = 0;
  int compared = 0;
  int mismatched = 0;
  int doneSeen = 0;

  typedef struct {
    logic [63:0] board;
    logic [15:0] count;
    int          doneCycle;
  } expect_t;
  expect_t sbQueue[$];

  life_data_high #(.X(X), .Y(Y), .HIGH_BITS(HB), .LOG2X(3), .LOG2Y(3)) dut (
    .clk           (clk),
    .reset         (resetN),
    .data_low_lsb  (dataLowLsb),
    .step          (stepReq),
    .run           (runReq),
    .data_high_lsb (dataHighLsb),
    .busy          (busy),
    .gen_done      (genDone),
    .gen_count     (genCount),
    .center_x      (centerX),
    .center_y      (centerY)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Low ring segment plus a preload path that feeds the board straight in.
  assign dataLowLsb = loading ? loadImage[(benchIdx + X + 2) % NC] : lowSeg[0];

  always @(posedge clk) begin
    lowSeg     <= {dataHighLsb, lowSeg[LOW-1:1]};
    cycleCount <= cycleCount + 1;
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) benchIdx <= 0;
    else         benchIdx <= (benchIdx == NC - 1) ? 0 : benchIdx + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] lifeStep(input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < Y; y++) begin
      for (int x = 0; x < X; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < X &&
                y + dy >= 0 && y + dy < Y)
              n += int'(b[(y + dy) * X + x + dx]);
          end
        end
        r[y * X + x] = (n == 3) || (b[y * X + x] && n == 2);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] cellAt(input int x, input int y);
    return 64'd1 << (y * X + x);
  endfunction

  // Scoreboard: each gen_done pops one expectation; ringView holds the last N
  // cells seen on data_high_lsb, i.e. the freshly written generation.
  always @(negedge clk) begin
    expect_t e;
    if (resetN && genDone) begin
      doneSeen <= doneSeen + 1;
      if (sbQueue.size() == 0) begin
        checkOutput("genDoneUnexpected", {63'd0, genDone}, 64'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("doneCycle", 64'(cycleCount), 64'(e.doneCycle));
        checkOutput("genCount", {48'd0, genCount}, {48'd0, e.count});
        checkOutput("board", ringView, e.board);
      end
    end
    ringView[(benchIdx + NC - X - 1) % NC] <= dataHighLsb;
  end

  task automatic loadBoard(input logic [63:0] b);
    @(negedge clk);
    loadImage = b;
    loading   = 1'b1;
    repeat (NC) @(negedge clk);
    loading  = 1'b0;
    curBoard = b;
  endtask

  task automatic applyStimulus(input bit useRun, input int gens, output int t0);
    int d;
    @(negedge clk);
    checkOutput("centerIdx", {58'd0, centerY, centerX}, 64'(benchIdx));
    checkOutput("idleBeforeRequest", {63'd0, busy}, 64'd0);
    d = (NC - benchIdx) % NC;
    if (d < 2) d += NC;
    t0 = cycleCount + d;
    for (int g = 0; g < gens; g++) begin
      expect_t e;
      curBoard    = lifeStep(curBoard);
      expCount    = expCount + 16'd1;
      e.board     = curBoard;
      e.count     = expCount;
      e.doneCycle = t0 + g * NC + NC + X + 1;
      sbQueue.push_back(e);
    end
    if (useRun) runReq = 1'b1;
    else        stepReq = 1'b1;
    @(negedge clk);
    stepReq = 1'b0;
    checkOutput("busyAfterRequest", {63'd0, busy}, 64'd1);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("drainTimeout", 64'(sbQueue.size()), 64'd0);
      sbQueue.delete();
    end
    n = 0;
    while (busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleAfterDrain", {63'd0, busy}, 64'd0);
  endtask

  task automatic waitUntilCycle(input int target);
    while (cycleCount < target) @(negedge clk);
  endtask

  initial begin
    int t0;
    int doneBase;
    logic [63:0] blinker;
    blinker = cellAt(3, 2) | cellAt(3, 3) | cellAt(3, 4);

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetGenCount", {48'd0, genCount}, 64'd0);
    checkOutput("resetGenDone", {63'd0, genDone}, 64'd0);
    checkOutput("resetCenter", {58'd0, centerY, centerX}, 64'd0);
    checkOutput("resetRingOut", {63'd0, dataHighLsb}, 64'd0);
    resetN = 1'b1;

    $display("[TB] timing and blinker, step at arbitrary index");
    loadBoard(blinker);
    repeat (17) @(negedge clk);
    applyStimulus(1'b0, 1, t0);
    waitDrain(300);

    $display("[TB] blinker back, step at last index");
    for (int n = 0; n < NC && benchIdx != NC - 2; n++) @(negedge clk);
    applyStimulus(1'b0, 1, t0);
    waitDrain(300);

    $display("[TB] block still life");
    loadBoard(cellAt(0, 0) | cellAt(1, 0) | cellAt(0, 1) | cellAt(1, 1));
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 1, t0);
      waitDrain(300);
    end

    $display("[TB] lone cell");
    loadBoard(cellAt(5, 5));
    applyStimulus(1'b0, 1, t0);
    waitDrain(300);

    $display("[TB] edge masking");
    loadBoard(cellAt(7, 1) | cellAt(7, 2) | cellAt(0, 2));
    applyStimulus(1'b0, 1, t0);
    waitDrain(300);

    $display("[TB] run mode");
    loadBoard(blinker);
    applyStimulus(1'b1, 4, t0);
    waitUntilCycle(t0 + 100);
    stepReq = 1'b1;
    @(negedge clk);
    stepReq = 1'b0;
    waitUntilCycle(t0 + 3 * NC + 10);
    runReq = 1'b0;
    waitDrain(600);
    doneBase = doneSeen;
    repeat (2 * NC) @(negedge clk);
    checkOutput("noExtraGenAfterRun", 64'(doneSeen - doneBase), 64'd0);

    $display("[TB] reset mid-compute");
    loadBoard(blinker);
    applyStimulus(1'b0, 1, t0);
    waitUntilCycle(t0 + 30);
    checkOutput("busyMidCompute", {63'd0, busy}, 64'd1);
    resetN = 1'b0;
    sbQueue.delete();
    expCount = '0;
    @(negedge clk);
    checkOutput("midResetBusy", {63'd0, busy}, 64'd0);
    checkOutput("midResetGenCount", {48'd0, genCount}, 64'd0);
    checkOutput("midResetGenDone", {63'd0, genDone}, 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    doneBase = doneSeen;
    repeat (150) @(negedge clk);
    checkOutput("noDoneAfterReset", 64'(doneSeen - doneBase), 64'd0);
    checkOutput("genCountAfterReset", {48'd0, genCount}, 64'd0);
    checkOutput("busyAfterReset", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
